// File: rtl/reg_file.sv
// MIPS architectural register file: 32 GPRs, two combinational read ports,
// one synchronous write port, optional same-cycle write-to-read forwarding.

module reg_file_rd_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic                                  i_rst_n,
   input  logic                                  i_we,
   input  logic [ADDR_W-1:0]                     i_waddr,
   input  logic [DATA_W-1:0]                     i_wdata,
   input  logic [ADDR_W-1:0]                     i_raddr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    i_ent,
   output logic [DATA_W-1:0]                     o_rdata
);

   logic w_hit;

   // Index 0 never forwards, so a discarded write to $zero stays invisible.
   assign w_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr) && (i_raddr != '0);

   always_comb begin
      o_rdata = i_ent[i_raddr];
      if (!i_rst_n)
         o_rdata = '0;
      else if (w_hit)
         o_rdata = i_wdata;
   end

endmodule

module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] w_ent;
   logic [1:0][ADDR_W-1:0]       w_raddr;
   logic [1:0][DATA_W-1:0]       w_rdata;

   // Entry 0 is a constant, not a flop; every other entry owns its own enable.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      if (g == 0) begin : g_zero
         assign w_ent[g] = '0;
      end else begin : g_reg
         logic [DATA_W-1:0] r_val;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_val <= '0;
            else if (we && (waddr == ADDR_W'(g)))
               r_val <= wdata;
         end
         assign w_ent[g] = r_val;
      end
   end

   assign w_raddr[0] = raddr1;
   assign w_raddr[1] = raddr2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_port (
         .i_rst_n (rst_n),
         .i_we    (we),
         .i_waddr (waddr),
         .i_wdata (wdata),
         .i_raddr (w_raddr[p]),
         .i_ent   (w_ent),
         .o_rdata (w_rdata[p])
      );
   end

   assign rdata1 = w_rdata[0];
   assign rdata2 = w_rdata[1];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one forwarding and one non-forwarding instance share
// stimulus; expected read data is queued as stimulus is driven, then popped.

module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   logic [31:0] mdl [32];

   always #5 clk = ~clk;

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b)
   );

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n)
   );

   // Drive a write at the falling edge and let the next rising edge take it.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk);
      if (a != 5'd0) mdl[a] = d;
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset;
      do_write(5'd5, 32'hDEADBEEF);
      do_write(5'd31, 32'h12345678);
      @(negedge clk);
      raddr1 = 5'd5; raddr2 = 5'd31;
      #1;
      exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h12345678);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v) begin failures++; $display("FAIL preload_r5 got=%h exp=%h", rd1_b, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd2_n !== exp_v) begin failures++; $display("FAIL preload_r31 got=%h exp=%h", rd2_n, exp_v); end
      // Assert reset between edges with a bypass-eligible write pending.
      #1;
      we = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd1_b, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd2_b !== exp_v || rd1_n !== exp_v || rd2_n !== exp_v) begin
         failures++; $display("FAIL reset_rd2 got=%h/%h/%h exp=%h", rd2_b, rd1_n, rd2_n, exp_v);
      end
      @(posedge clk); #1;
      checks++;
      if (rd1_b !== 32'h0) begin failures++; $display("FAIL reset_write_ignored got=%h exp=0", rd1_b); end
      @(negedge clk);
      we = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL post_reset_r5 got=%h/%h exp=%h", rd1_b, rd1_n, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd2_b !== exp_v || rd2_n !== exp_v) begin failures++; $display("FAIL post_reset_r31 got=%h/%h exp=%h", rd2_b, rd2_n, exp_v); end
   endtask

   task automatic test_basic;
      do_write(5'd7, 32'hA5A5A5A5);
      @(negedge clk);
      raddr1 = 5'd7; raddr2 = 5'd7;
      #1;
      exp_q.push_back(32'hA5A5A5A5);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd2_b !== exp_v || rd1_n !== exp_v || rd2_n !== exp_v) begin
         failures++; $display("FAIL basic_r7 got=%h/%h/%h/%h exp=%h", rd1_b, rd2_b, rd1_n, rd2_n, exp_v);
      end
      raddr2 = 5'd8;
      #1;
      exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); checks++;
      if (rd2_b !== exp_v || rd2_n !== exp_v) begin failures++; $display("FAIL basic_r8 got=%h/%h exp=%h", rd2_b, rd2_n, exp_v); end
   endtask

   task automatic test_zero;
      @(negedge clk);
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
      #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL zero_same_cycle got=%h/%h exp=%h", rd1_b, rd1_n, exp_v); end
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL zero_next_cycle got=%h/%h exp=%h", rd1_b, rd1_n, exp_v); end
   endtask

   task automatic test_bypass;
      do_write(5'd3, 32'h00000011);
      @(negedge clk);
      we = 1'b1; waddr = 5'd3; wdata = 32'h00000022; raddr1 = 5'd3; raddr2 = 5'd3;
      #1;
      exp_q.push_back(32'h22); exp_q.push_back(32'h11); exp_q.push_back(32'h22);
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd2_b !== exp_v) begin failures++; $display("FAIL bypass_before_edge got=%h/%h exp=%h", rd1_b, rd2_b, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_n !== exp_v || rd2_n !== exp_v) begin failures++; $display("FAIL nobypass_before_edge got=%h/%h exp=%h", rd1_n, rd2_n, exp_v); end
      @(posedge clk); mdl[3] = 32'h22; #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL bypass_after_edge got=%h/%h exp=%h", rd1_b, rd1_n, exp_v); end
      we = 1'b0;
   endtask

   task automatic test_hold;
      do_write(5'd9, 32'h00000001);
      @(negedge clk);
      we = 1'b0; waddr = 5'd9; wdata = 32'hCAFEF00D; raddr1 = 5'd9;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(32'h00000001);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front(); checks++;
         if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL hold_edge%0d got=%h/%h exp=%h", k, rd1_b, rd1_n, exp_v); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] vals [4];
      vals[0] = 32'h10203040; vals[1] = 32'h50607080;
      vals[2] = 32'h90A0B0C0; vals[3] = 32'hD0E0F000;
      @(negedge clk);
      raddr1 = 5'd4; we = 1'b1; waddr = 5'd4; wdata = vals[0];
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); mdl[4] = vals[k-1]; #1;
         wdata = vals[k];
         #1;
         exp_q.push_back(vals[k]); exp_q.push_back(vals[k-1]);
         exp_v = exp_q.pop_front(); checks++;
         if (rd1_b !== exp_v) begin failures++; $display("FAIL b2b_byp_%0d got=%h exp=%h", k, rd1_b, exp_v); end
         exp_v = exp_q.pop_front(); checks++;
         if (rd1_n !== exp_v) begin failures++; $display("FAIL b2b_nob_%0d got=%h exp=%h", k, rd1_n, exp_v); end
      end
      @(posedge clk); mdl[4] = vals[3]; #1;
      we = 1'b0;
      #1;
      checks++;
      if (rd1_n !== vals[3] || rd1_b !== vals[3]) begin failures++; $display("FAIL b2b_last got=%h/%h exp=%h", rd1_b, rd1_n, vals[3]); end
   endtask

   task automatic test_sweep;
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i); raddr2 = 5'(31 - i);
         exp_q.push_back(mdl[i]); exp_q.push_back(mdl[31 - i]);
         #1;
         exp_v = exp_q.pop_front(); checks++;
         if (rd1_b !== exp_v || rd1_n !== exp_v) begin failures++; $display("FAIL sweep_rd1_%0d got=%h/%h exp=%h", i, rd1_b, rd1_n, exp_v); end
         exp_v = exp_q.pop_front(); checks++;
         if (rd2_b !== exp_v || rd2_n !== exp_v) begin failures++; $display("FAIL sweep_rd2_%0d got=%h/%h exp=%h", 31 - i, rd2_b, rd2_n, exp_v); end
      end
      checks++;
      if (mdl[0] !== 32'h0 || mdl[31] !== 32'h1F1F1F1F) begin failures++; $display("FAIL sweep_model got=%h/%h exp=0/1f1f1f1f", mdl[0], mdl[31]); end
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_zero();
      test_bypass();
      test_hold();
      test_back_to_back();
      test_sweep();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
